mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port alu_start  input  1  one-cycle request pulse from the control unit.
REQ-005 SHALL have port Alu_Func  input  5  operation code: 5'b00010 multiply, 5'b00011 divide.
REQ-006 SHALL have port src_a  input  WIDTH  first operand, dividend for divide.
REQ-007 SHALL have port src_b  input  WIDTH  second operand, divisor for divide.
REQ-008 SHALL have port result  output  WIDTH  registered result of the last completed operation.
REQ-009 SHALL have port alu_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress, including the DONE cycle.

Function
REQ-011 SHALL implement four states: IDLE, MUL, DIV and DONE.
REQ-012 SHALL accept a request only in IDLE, on an edge where alu_start=1 and Alu_Func is 00010 or 00011, latching src_a, src_b and Alu_Func on that edge.
REQ-013 SHALL ignore alu_start with any other Alu_Func code: stay in IDLE, no alu_valid, result unchanged.
REQ-014 SHALL ignore alu_start while busy=1; the latched operands are not disturbed.
REQ-015 SHALL move from IDLE to MUL or DIV on acceptance and run exactly WIDTH iterations, one per clock, using an iteration counter that counts 0..WIDTH-1.
REQ-016 SHALL enter DONE after the last iteration; in DONE, alu_valid=1 for exactly one cycle, then return to IDLE.
REQ-017 SHALL assert alu_valid during the cycle following the (WIDTH+1)th rising edge after the accepting edge; for WIDTH=32 this is 33 edges.
REQ-018 Multiply SHALL use shift-add and produce the low WIDTH bits of src_a*src_b; the result is identical for signed and unsigned operands.
REQ-019 Divide SHALL be signed restoring division on the absolute values of the operands.
REQ-020 Divide SHALL give a negative quotient when the operand sign bits differ, truncated toward zero.
REQ-021 Divide by zero SHALL give all ones (0xFFFFFFFF), regardless of the sign of src_a.
REQ-022 Divide of the most negative value by -1 SHALL give 0x80000000, with no exception.
REQ-023 SHALL update result only on entry to DONE and hold it stable until the next completed operation.
REQ-024 SHALL allow a new request on the first IDLE cycle after DONE; back-to-back operations are allowed.

Reset
REQ-025 When rst=0 at a rising edge, SHALL enter IDLE and clear result, alu_valid, busy, the iteration counter and all internal registers to 0.
REQ-026 Reset mid-operation SHALL abort the operation with no alu_valid pulse; the first accepted request after reset release SHALL complete normally.
REQ-027 Reset SHALL take priority over alu_start on the same edge.

Configuration
REQ-028 Macro MUL_DIV_UNIT_DIV_EN defined SHALL build the divider as specified in REQ-019..REQ-022.
REQ-029 Macro MUL_DIV_UNIT_DIV_EN undefined SHALL omit the divider and DIV state; a divide request is accepted, goes directly to DONE, and pulses alu_valid on the second edge after acceptance with result=0.

Verification
REQ-030 Multiply: src_a=7, src_b=6, code 00010 -> alu_valid one cycle, 33 edges after acceptance, result=42.
REQ-031 Signed divide: src_a=-20 (0xFFFFFFEC), src_b=3, code 00011 -> result=0xFFFFFFFA (-6); then src_a=0x80000000, src_b=0xFFFFFFFF -> result=0x80000000.
REQ-032 Divide by zero: src_a=5 then src_a=-5, with src_b=0 -> result=0xFFFFFFFF both times.
REQ-033 Ignored start: code 00000 with start -> no alu_valid within 40 cycles and busy=0; start pulse at cycle 10 of a multiply -> first result unaffected, only one alu_valid.
REQ-034 Reset abort: rst=0 at iteration 15 of a multiply -> result=0, busy=0, no alu_valid; next request 3*4 -> result=12.
REQ-035 Multiply overflow: 0xFFFFFFFF*0xFFFFFFFF -> result=1; with MUL_DIV_UNIT_DIV_EN undefined, divide 9/3 -> result=0 and alu_valid two edges after acceptance.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiplier and restoring signed divider, one bit per clock.
// Define MUL_DIV_UNIT_DIV_EN to build the divider; otherwise divide requests complete with result 0.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_start,
  input  logic [4:0]       Alu_Func,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             alu_valid,
  output logic             busy,
  output logic [1:0]       dbg_state
);
  // Handshake: a request is taken on any edge with state IDLE, alu_start=1 and a known
  // Alu_Func; alu_valid then pulses for exactly one cycle with result already stable.
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [4:0]    FUNC_MUL = 5'b00010;
  localparam logic [4:0]    FUNC_DIV = 5'b00011;
  localparam logic [1:0]    IDLE     = 2'd0;
  localparam logic [1:0]    MUL      = 2'd1;
`ifdef MUL_DIV_UNIT_DIV_EN
  localparam logic [1:0]    DIV      = 2'd2;
`endif
  localparam logic [1:0]    DONE     = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [4:0]       func_q;
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH-1:0] final_val;
`ifdef MUL_DIV_UNIT_DIV_EN
  logic             neg_q;
  logic             zero_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_q_nxt;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
`else
  logic             settle_q;
`endif

  // In MUL: acc is the partial product, opa the shifted multiplicand, opb the shifted multiplier.
  // In DIV: acc is the partial remainder, opa shifts dividend bits out and quotient bits in.
  always_comb begin
    mul_acc_nxt = opb[0] ? acc + opa : acc;
`ifdef MUL_DIV_UNIT_DIV_EN
    rem_sh      = {acc, opa[WIDTH-1]};
    trial       = rem_sh - {1'b0, opb};
    div_rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    div_q_nxt   = {opa[WIDTH-2:0], ~trial[WIDTH]};
    if (func_q != FUNC_DIV)  final_val = mul_acc_nxt;
    else if (zero_q)         final_val = '1;
    else if (neg_q)          final_val = -div_q_nxt;
    else                     final_val = div_q_nxt;
`else
    final_val   = mul_acc_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      opa       <= '0;
      opb       <= '0;
      func_q    <= '0;
      result    <= '0;
      alu_valid <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
`else
      settle_q  <= 1'b0;
`endif
    end else begin
      alu_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (alu_start && Alu_Func == FUNC_MUL) begin
            func_q <= Alu_Func;
            opa    <= src_a;
            opb    <= src_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end else if (alu_start && Alu_Func == FUNC_DIV) begin
            func_q <= Alu_Func;
            acc    <= '0;
            cnt    <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
            opa    <= abs_val(src_a);
            opb    <= abs_val(src_b);
            neg_q  <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
            zero_q <= (src_b == '0);
            state  <= DIV;
`else
            opa      <= src_a;
            opb      <= src_b;
            settle_q <= 1'b0;
            result   <= '0;
            state    <= DONE;
`endif
          end
        end
        MUL: begin
          acc <= mul_acc_nxt;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= final_val;
            state  <= DONE;
          end
        end
`ifdef MUL_DIV_UNIT_DIV_EN
        DIV: begin
          acc <= div_rem_nxt;
          opa <= div_q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= final_val;
            state  <= DONE;
          end
        end
`endif
        DONE: begin
`ifdef MUL_DIV_UNIT_DIV_EN
          alu_valid <= 1'b1;
          state     <= IDLE;
`else
          // A divide without the divider holds one extra cycle so it completes two edges after acceptance.
          if (func_q == FUNC_DIV && !settle_q) begin
            settle_q <= 1'b1;
          end else begin
            settle_q  <= 1'b0;
            alu_valid <= 1'b1;
            state     <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
